// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared 16-bit ALU
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_op,

  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_s,
  input  logic [15:0] alu_res,
  input  logic [3:0]  alu_flag,

  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  output logic [3:0]  rsp0_flag,
  input  logic        rsp0_ready,

  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  output logic [3:0]  rsp1_flag,
  input  logic        rsp1_ready
);

  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state;

  // last_grant: requester served most recently (1 after reset so requester 0 wins the first tie)
  logic last_grant;
  // grant_idx: owner of the operation currently in flight
  logic grant_idx;

  logic grant_any;
  logic grant_sel;
  logic grant_fire;
  logic rsp_ready_sel;

  // Round-robin pick: a lone requester always wins, a tie goes to the one not served last
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req1_valid;
    end
  end

  // Grant only in IDLE and never while reset is being applied
  assign grant_fire = !rst && (state == ST_IDLE) && grant_any;
  assign req0_ready = grant_fire && !grant_sel;
  assign req1_ready = grant_fire &&  grant_sel;

  // Consumer handshake of whichever requester owns the pending response
  assign rsp_ready_sel = grant_idx ? rsp1_ready : rsp0_ready;

  // Single-slot controller: grant, drive the ALU for one cycle, hold the response until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_idx  <= 1'b0;
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_s      <= ALU_NOP;
      rsp0_valid <= 1'b0;
      rsp0_data  <= 16'h0000;
      rsp0_flag  <= 4'b0000;
      rsp1_valid <= 1'b0;
      rsp1_data  <= 16'h0000;
      rsp1_flag  <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            grant_idx  <= grant_sel;
            last_grant <= grant_sel;
            // Operands land directly in the ALU drive registers, so they are
            // visible on the ALU bus exactly during the ISSUE cycle.
            if (grant_sel) begin
              alu_a <= req1_a;
              alu_b <= req1_b;
              alu_s <= req1_op;
            end else begin
              alu_a <= req0_a;
              alu_b <= req0_b;
              alu_s <= req0_op;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Result and flags are taken verbatim; only the owner's slot changes
          if (grant_idx) begin
            rsp1_data  <= alu_res;
            rsp1_flag  <= alu_flag;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_data  <= alu_res;
            rsp0_flag  <= alu_flag;
            rsp0_valid <= 1'b1;
          end
          alu_a <= 16'h0000;
          alu_b <= 16'h0000;
          alu_s <= ALU_NOP;
          state <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready_sel) begin
            if (grant_idx) begin
              rsp1_valid <= 1'b0;
            end else begin
              rsp0_valid <= 1'b0;
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_a [2];
  logic [15:0] req_b [2];
  logic [3:0]  req_op [2];
  logic [1:0]  rsp_ready;

  logic        req0_ready, req1_ready;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_s;
  logic [15:0] alu_res;
  logic [3:0]  alu_flag;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_flag, rsp1_flag;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last_data [2];
  logic [3:0]  last_flag [2];

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req0_ready),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req0_op    (req_op[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req1_ready),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .req1_op    (req_op[1]),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_res    (alu_res),
    .alu_flag   (alu_flag),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_flag  (rsp0_flag),
    .rsp0_ready (rsp_ready[0]),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_flag  (rsp1_flag),
    .rsp1_ready (rsp_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB (C = borrow), 2 AND, 3 OR, 4 XOR, anything else yields 0
  logic [16:0] wide;
  logic        c_bit, v_bit;
  always_comb begin
    wide    = 17'h0;
    c_bit   = 1'b0;
    v_bit   = 1'b0;
    alu_res = 16'h0000;
    case (alu_s)
      4'h0: begin
        wide    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = wide[15:0];
        c_bit   = wide[16];
        v_bit   = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
      end
      4'h1: begin
        wide    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res = wide[15:0];
        c_bit   = wide[16];
        v_bit   = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
      end
      4'h2: alu_res = alu_a & alu_b;
      4'h3: alu_res = alu_a | alu_b;
      4'h4: alu_res = alu_a ^ alu_b;
      default: alu_res = 16'h0000;
    endcase
    alu_flag = {alu_res[15], (alu_res == 16'h0000), c_bit, v_bit};
  end

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    logic [3:0]  exp_flag;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input int i);
    return (i == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic [15:0] data_of(input int i);
    return (i == 1) ? rsp1_data : rsp0_data;
  endfunction

  function automatic logic [3:0] flag_of(input int i);
    return (i == 1) ? rsp1_flag : rsp0_flag;
  endfunction

  task automatic present(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
  endtask

  // One full transaction from IDLE on a single requester, checking every phase
  task automatic do_op(input vec_t v);
    int o;
    o = 1 - v.idx;
    present(v.idx, v.op, v.a, v.b);
    #1;
    chk("grant_ready", ready_of(v.idx), 1'b1);
    chk("grant_other_ready", ready_of(o), 1'b0);
    cyc();
    req_valid[v.idx] = 1'b0;
    #1;
    chk("issue_alu_s", alu_s, v.op);
    chk("issue_alu_a", alu_a, v.a);
    chk("issue_alu_b", alu_b, v.b);
    chk("issue_no_ready", {req1_ready, req0_ready}, 2'b00);
    chk("issue_no_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    cyc();
    chk("resp_valid", {rsp1_valid, rsp0_valid}, (v.idx == 1) ? 2'b10 : 2'b01);
    chk("resp_data", data_of(v.idx), v.exp_data);
    chk("resp_flag", flag_of(v.idx), v.exp_flag);
    chk("resp_other_data", data_of(o), last_data[o]);
    chk("resp_other_flag", flag_of(o), last_flag[o]);
    chk("resp_alu_nop", alu_s, 4'hF);
    rsp_ready[v.idx] = 1'b1;
    cyc();
    rsp_ready[v.idx] = 1'b0;
    #1;
    chk("after_hs_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    last_data[v.idx] = v.exp_data;
    last_flag[v.idx] = v.exp_flag;
  endtask

  initial begin
    vecs[0] = '{0, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
    vecs[1] = '{1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 4'b0100};
    vecs[2] = '{0, 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
    vecs[3] = '{1, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
    vecs[4] = '{0, 4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
    vecs[5] = '{1, 4'h4, 16'h8000, 16'h0001, 16'h8001, 4'b1000};
    vecs[6] = '{0, 4'hA, 16'h1234, 16'h5678, 16'h0000, 4'b0100};
    vecs[7] = '{1, 4'h3, 16'h8000, 16'h0F00, 16'h8F00, 4'b1000};

    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 16'h0; req_b[i] = 16'h0; req_op[i] = 4'h0;
      last_data[i] = 16'h0; last_flag[i] = 4'h0;
    end

    // Reset state, including no grant while reset is held
    cyc();
    cyc();
    present(0, 4'h0, 16'h1111, 16'h2222);
    #1;
    chk("rst_no_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_rsp_data", {rsp1_data, rsp0_data}, 32'h0);
    chk("rst_rsp_flag", {rsp1_flag, rsp0_flag}, 8'h0);
    chk("rst_alu_s", alu_s, 4'hF);
    chk("rst_alu_ab", {alu_b, alu_a}, 32'h0);
    req_valid = 2'b00;
    rst = 1'b0;
    cyc();

    // Round-robin: tie after reset goes to 0, then 1, then 0
    present(0, 4'h0, 16'h0001, 16'h0002);
    present(1, 4'h1, 16'h0009, 16'h0004);
    #1;
    chk("rr1_ready", {req1_ready, req0_ready}, 2'b01);
    cyc();
    req_valid[0] = 1'b0;
    #1;
    chk("rr1_issue_no_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rr1_issue_alu_a", alu_a, 16'h0001);
    cyc();
    chk("rr1_resp_data", rsp0_data, 16'h0003);
    present(0, 4'h0, 16'h0010, 16'h0020);
    #1;
    chk("rr1_resp_no_ready", {req1_ready, req0_ready}, 2'b00);
    rsp_ready[0] = 1'b1;
    cyc();
    rsp_ready[0] = 1'b0;
    #1;
    chk("rr2_ready", {req1_ready, req0_ready}, 2'b10);
    cyc();
    req_valid[1] = 1'b0;
    #1;
    chk("rr2_issue_alu_a", alu_a, 16'h0009);
    cyc();
    chk("rr2_resp_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("rr2_resp_data", rsp1_data, 16'h0005);
    present(1, 4'h4, 16'h00FF, 16'h0F0F);
    rsp_ready[1] = 1'b1;
    cyc();
    rsp_ready[1] = 1'b0;
    #1;
    chk("rr3_ready", {req1_ready, req0_ready}, 2'b01);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    chk("rr3_resp_data", rsp0_data, 16'h0030);
    rsp_ready[0] = 1'b1;
    cyc();
    rsp_ready[0] = 1'b0;
    #1;
    chk("rr4_ready", {req1_ready, req0_ready}, 2'b10);
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    chk("rr4_resp_data", rsp1_data, 16'h0FF0);
    rsp_ready[1] = 1'b1;
    cyc();
    rsp_ready[1] = 1'b0;
    last_data[0] = 16'h0030; last_flag[0] = 4'b0000;
    last_data[1] = 16'h0FF0; last_flag[1] = 4'b0000;

    // Table of single-requester operations
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i]);
    end

    // Response back-pressure with the other requester waiting
    present(0, 4'h3, 16'h0001, 16'h0002);
    #1;
    chk("stall_grant", req0_ready, 1'b1);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    present(1, 4'h0, 16'h0004, 16'h0004);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", {rsp1_valid, rsp0_valid}, 2'b01);
      chk("stall_data", rsp0_data, 16'h0003);
      chk("stall_flag", rsp0_flag, 4'b0000);
      chk("stall_no_ready", {req1_ready, req0_ready}, 2'b00);
      chk("stall_alu_nop", alu_s, 4'hF);
      cyc();
    end
    rsp_ready[0] = 1'b1;
    #1;
    chk("stall_last_valid", rsp0_valid, 1'b1);
    cyc();
    rsp_ready[0] = 1'b0;
    #1;
    chk("stall_then_grant1", {req1_ready, req0_ready}, 2'b10);
    chk("stall_cleared", rsp0_valid, 1'b0);
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    chk("stall_rsp1_data", rsp1_data, 16'h0008);
    chk("stall_rsp0_kept", rsp0_data, 16'h0003);
    rsp_ready[1] = 1'b1;
    cyc();
    rsp_ready[1] = 1'b0;

    // Reset during ISSUE aborts the operation; request is re-granted afterwards
    present(0, 4'h0, 16'h0100, 16'h0200);
    #1;
    chk("abort_grant", req0_ready, 1'b1);
    cyc();
    rst = 1'b1;
    #1;
    chk("abort_rst_no_ready", {req1_ready, req0_ready}, 2'b00);
    cyc();
    rst = 1'b0;
    #1;
    chk("abort_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("abort_rsp_data", {rsp1_data, rsp0_data}, 32'h0);
    chk("abort_rsp_flag", {rsp1_flag, rsp0_flag}, 8'h0);
    chk("abort_alu_s", alu_s, 4'hF);
    chk("abort_alu_ab", {alu_b, alu_a}, 32'h0);
    chk("abort_regrant", {req1_ready, req0_ready}, 2'b01);
    cyc();
    req_valid[0] = 1'b0;
    #1;
    chk("abort_issue_alu_a", alu_a, 16'h0100);
    cyc();
    chk("abort_resp_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("abort_resp_data", rsp0_data, 16'h0300);
    rsp_ready[0] = 1'b1;
    cyc();
    rsp_ready[0] = 1'b0;
    #1;
    chk("abort_done", {rsp1_valid, rsp0_valid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits and the opcode width at 4 bits.
REQ-002 CLK  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 REQn_VALID  in  1  (n=0,1) requester n presents an operation.
REQ-005 REQn_READY  out  1  (n=0,1) operation accepted this cycle.
REQ-006 REQn_A, REQn_B  in  16  (n=0,1) signed operands.
REQ-007 REQn_OP  in  4  (n=0,1) ALU selector code.
REQ-008 ALU_A, ALU_B  out  16  operands driven to the shared ALU.
REQ-009 ALU_S  out  4  selector driven to the shared ALU.
REQ-010 ALU_RES  in  16  ALU result.
REQ-011 ALU_FLAG  in  4  ALU flags {S,Z,C,V}.
REQ-012 RSPn_VALID  out  1  (n=0,1) response available for requester n.
REQ-013 RSPn_DATA  out  16  (n=0,1) captured result.
REQ-014 RSPn_FLAG  out  4  (n=0,1) captured flags.
REQ-015 RSPn_READY  in  1  (n=0,1) requester n consumes the response.

Function
REQ-016 States SHALL be IDLE, ISSUE, RESP; exactly one operation SHALL be in flight at a time.
REQ-017 In IDLE, with any REQn_VALID high, the block SHALL grant exactly one requester; REQn_READY SHALL be combinationally high for the winner in that cycle only, then transition to ISSUE.
REQ-018 Arbitration SHALL be round-robin: if both are valid, the requester not granted last wins; if one is valid, it wins regardless of the pointer.
REQ-019 On grant, the block SHALL register operands, opcode and the grant index; the last-granted pointer SHALL update on grant.
REQ-020 In ISSUE (one cycle), ALU_A/ALU_B/ALU_S SHALL be driven from the registered values, and ALU_RES/ALU_FLAG SHALL be captured into the response registers at the end of that cycle; next state RESP.
REQ-021 Outside ISSUE, ALU_S SHALL be 4'b1111 (no-op) and ALU_A, ALU_B SHALL be 16'h0000.
REQ-022 In RESP, only RSPg_VALID (g = grant index) SHALL be high; RSPg_DATA/RSPg_FLAG SHALL stay stable until RSPg_READY is sampled high, then next state IDLE.
REQ-023 A handshake asserted in the first RESP cycle SHALL complete in that cycle.
REQ-024 Latency: grant at cycle t, then RSPg_VALID high at t+2; minimum issue interval is 3 cycles.
REQ-025 No REQn_READY SHALL be asserted in ISSUE or RESP; requests SHALL wait with operands held stable.
REQ-026 RSPn_DATA/RSPn_FLAG of the non-granted requester SHALL retain their previous values.
REQ-027 Opcodes SHALL pass through unchecked; the block SHALL not interpret operands, results or flags.
REQ-028 A response to requester g SHALL NOT be blocked by traffic from the other requester (no reordering; single slot).

Reset
REQ-029 On RST: state IDLE, last-granted pointer = 1 (requester 0 wins first tie), all RSPn_VALID = 0, RSPn_DATA = 16'h0000, RSPn_FLAG = 4'b0000, ALU_S = 4'b1111, ALU_A = ALU_B = 16'h0000.
REQ-030 RST during ISSUE or RESP SHALL abort the operation with no response delivered and no REQn_READY asserted in the reset cycle.
REQ-031 RST SHALL take priority over every other event in the same cycle.

Verification
REQ-032 REQ0 ADD (OP=0000) with A=16'h7FFF, B=16'h0001 -> RSP0_VALID at grant+2, RSP0_DATA=16'h8000, RSP0_FLAG=4'b1001.
REQ-033 REQ1 SUB (OP=0001) with A=B=16'h0005 -> RSP1_DATA=16'h0000, RSP1_FLAG=4'b0100; RSP0_VALID stays 0.
REQ-034 Both valid right after reset, both holding -> REQ0 granted first, REQ1 granted on the next IDLE; both valid again -> REQ0 granted (alternation).
REQ-035 RSP0_READY held low for 5 cycles in RESP -> RSP0_VALID/DATA/FLAG stable, no REQn_READY pulses, ALU_S = 4'b1111 throughout.
REQ-036 RST asserted in ISSUE -> the next cycle shows IDLE with all outputs at reset values, and the aborted request is re-granted once RST deasserts if it is still valid.
